// File: rtl/pipe_ctrl_sched_pkg.sv
// y86_pkg: shared Y86-64 encodings plus control-unit state and control-bundle types.
package y86_pkg;
    localparam logic [1:0] AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3;
    localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3,
                           RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7,
                           CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB;
    localparam logic [3:0] RNONE = 4'hF;
    typedef enum logic [1:0] {RUN, DBG_HALT, STEP, FAULT} ctrl_state_e;
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_stall;
        logic e_bubble;
        logic m_stall;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
    } ctrl_t;
    localparam ctrl_t FROZEN_CTL = '{f_stall: 1'b1, d_stall: 1'b1, d_bubble: 1'b0, e_stall: 1'b1,
                                     e_bubble: 1'b0, m_stall: 1'b1, m_bubble: 1'b0, w_stall: 1'b1,
                                     set_cc: 1'b0};
    localparam ctrl_t FAULT_CTL  = '{f_stall: 1'b1, d_stall: 1'b1, d_bubble: 1'b0, e_stall: 1'b0,
                                     e_bubble: 1'b1, m_stall: 1'b0, m_bubble: 1'b1, w_stall: 1'b1,
                                     set_cc: 1'b0};
endpackage

// File: rtl/pipe_ctrl_sched_if.sv
// pipe_ctrl_sched_if: stage status in, register controls and perf counters out.
interface pipe_ctrl_sched_if #(parameter int CNT_W = 32);
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic             e_Cnd, dbg_halt_req, dbg_step;
    logic [1:0]       m_stat, W_stat;
    logic             F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall;
    logic             set_cc, dbg_halted, fault;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, bubble_cnt, retire_cnt;
    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_icode, W_stat,
               dbg_halt_req, dbg_step,
        input  F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall,
               set_cc, dbg_halted, fault, cyc_cnt, stall_cnt, bubble_cnt, retire_cnt
    );
    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_icode, W_stat,
               dbg_halt_req, dbg_step,
        output F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall,
               set_cc, dbg_halted, fault, cyc_cnt, stall_cnt, bubble_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sched_hazard_detect.sv
// hazard_detect: combinational load/use, ret, mispredict and exception terms.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [1:0] m_stat,
    input  logic [1:0] W_stat,
    output logic       lu,
    output logic       rt,
    output logic       mp,
    output logic       exc
);
    assign lu  = (E_icode == MRMOVQ || E_icode == POPQ) && E_dstM != RNONE &&
                 (E_dstM == d_srcA || E_dstM == d_srcB);
    assign rt  = D_icode == RET || E_icode == RET || M_icode == RET;
    assign mp  = E_icode == JXX && !e_Cnd;
    assign exc = m_stat != AOK || W_stat != AOK;
endmodule

// File: rtl/pipe_ctrl_sched.sv
// pipe_ctrl_sched: Y86-64 pipeline stall/bubble control with run/debug/fault FSM and perf counters.
module pipe_ctrl_sched
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_ctrl_sched_if.slave   bus
);
    logic lu, rt, mp, exc, active;
    ctrl_state_e st, nxt, mode;
    ctrl_t norm, ctl;
    logic [CNT_W-1:0] cyc_c, stall_c, bubble_c, retire_c;

    hazard_detect u_hazard (
        .D_icode(bus.D_icode), .d_srcA(bus.d_srcA), .d_srcB(bus.d_srcB),
        .E_icode(bus.E_icode), .E_dstM(bus.E_dstM), .e_Cnd(bus.e_Cnd),
        .M_icode(bus.M_icode), .m_stat(bus.m_stat), .W_stat(bus.W_stat),
        .lu(lu), .rt(rt), .mp(mp), .exc(exc)
    );

    always_comb begin
        nxt = st;
        if (bus.W_stat != AOK) nxt = FAULT;
        else if (st == RUN) nxt = bus.dbg_halt_req ? DBG_HALT : RUN;
        else if (st == DBG_HALT) nxt = bus.dbg_step ? STEP : (bus.dbg_halt_req ? DBG_HALT : RUN);
        else if (st == STEP) nxt = bus.dbg_halt_req ? DBG_HALT : RUN;
    end

    always_comb begin
        norm          = '0;
        norm.f_stall  = lu | rt;
        norm.d_stall  = lu;
        norm.d_bubble = (mp | (rt & !lu)) & !norm.d_stall;
        norm.e_bubble = mp | lu;
        norm.m_bubble = exc;
        norm.w_stall  = bus.W_stat != AOK;
        norm.set_cc   = bus.E_icode == OPQ && !exc;
    end

    // Outputs behave as RUN while reset is asserted, whatever the registered state.
    assign mode   = rst_n ? st : RUN;
    assign ctl    = mode == DBG_HALT ? FROZEN_CTL : mode == FAULT ? FAULT_CTL : norm;
    assign active = st == RUN || st == STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= RUN;
            cyc_c    <= '0;
            stall_c  <= '0;
            bubble_c <= '0;
            retire_c <= '0;
        end else begin
            st <= nxt;
            if (active) begin
                cyc_c    <= cyc_c + CNT_W'(1);
                stall_c  <= stall_c + CNT_W'(ctl.f_stall);
                bubble_c <= bubble_c + CNT_W'(ctl.d_bubble | ctl.e_bubble);
                retire_c <= retire_c + CNT_W'(bus.W_stat == AOK && bus.W_icode != NOP && bus.W_icode != HALT);
            end
        end
    end

    assign bus.F_stall    = ctl.f_stall;
    assign bus.D_stall    = ctl.d_stall;
    assign bus.D_bubble   = ctl.d_bubble;
    assign bus.E_stall    = ctl.e_stall;
    assign bus.E_bubble   = ctl.e_bubble;
    assign bus.M_stall    = ctl.m_stall;
    assign bus.M_bubble   = ctl.m_bubble;
    assign bus.W_stall    = ctl.w_stall;
    assign bus.set_cc     = ctl.set_cc;
    assign bus.dbg_halted = mode == DBG_HALT;
    assign bus.fault      = mode == FAULT;
    assign bus.cyc_cnt    = cyc_c;
    assign bus.stall_cnt  = stall_c;
    assign bus.bubble_cnt = bubble_c;
    assign bus.retire_cnt = retire_c;
endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// tb_pipe_ctrl_sched: directed scenarios for hazard controls, debug FSM, fault and counters.
module tb_pipe_ctrl_sched;
    import y86_pkg::*;
    logic clk, rst_n;
    int checks, failures;
    int e_cyc, e_stall, e_bub, e_ret;
    logic [8:0] ctl;

    pipe_ctrl_sched_if #(.CNT_W(32)) bus();
    pipe_ctrl_sched #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Bit order: F_stall D_stall D_bubble E_stall E_bubble M_stall M_bubble W_stall set_cc
    assign ctl = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_stall, bus.E_bubble,
                  bus.M_stall, bus.M_bubble, bus.W_stall, bus.set_cc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.D_icode = NOP; bus.d_srcA = RNONE; bus.d_srcB = RNONE;
        bus.E_icode = NOP; bus.E_dstM = RNONE; bus.e_Cnd = 1'b1;
        bus.M_icode = NOP; bus.m_stat = AOK; bus.W_icode = NOP; bus.W_stat = AOK;
        bus.dbg_halt_req = 1'b0; bus.dbg_step = 1'b0;
    endtask

    task automatic advance(input int c, input int s, input int b, input int r);
        e_cyc += c; e_stall += s; e_bub += b; e_ret += r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.E_icode = MRMOVQ; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
        repeat (2) @(negedge clk);
        e_cyc = 0; e_stall = 0; e_bub = 0; e_ret = 0;
        checks++;
        if ({bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt} !== 128'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d %0d %0d %0d want 0 0 0 0", bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt);
        end
        checks++;
        if ({bus.dbg_halted, bus.fault} !== 2'b00) begin
            failures++; $display("FAIL reset_flags got %b want 00", {bus.dbg_halted, bus.fault});
        end
        checks++;
        if (ctl !== 9'b110010000) begin
            failures++; $display("FAIL reset_ctl got %b want 110010000", ctl);
        end
        idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== 9'b000000000) begin
            failures++; $display("FAIL idle_ctl got %b want 000000000", ctl);
        end
        advance(1, 0, 0, 0);
    endtask

    task automatic test_load_use();
        bus.E_icode = MRMOVQ; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
        #1;
        checks++;
        if (ctl !== 9'b110010000) begin
            failures++; $display("FAIL load_use got %b want 110010000", ctl);
        end
        advance(1, 1, 1, 0);
        bus.E_icode = POPQ; bus.E_dstM = RNONE; bus.d_srcA = RNONE;
        #1;
        checks++;
        if (ctl !== 9'b000000000) begin
            failures++; $display("FAIL load_use_rnone got %b want 000000000", ctl);
        end
        advance(1, 0, 0, 0);
        idle();
        checks++;
        if ({bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt} !== {e_cyc[31:0], e_stall[31:0], e_bub[31:0]}) begin
            failures++;
            $display("FAIL load_use_cnt got %0d %0d %0d want %0d %0d %0d", bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, e_cyc, e_stall, e_bub);
        end
    endtask

    task automatic test_ret();
        bus.D_icode = RET;
        #1;
        checks++;
        if (ctl !== 9'b101000000) begin
            failures++; $display("FAIL ret_d got %b want 101000000", ctl);
        end
        advance(1, 1, 1, 0);
        bus.E_icode = MRMOVQ; bus.E_dstM = 4'd2; bus.d_srcB = 4'd2;
        #1;
        checks++;
        if (ctl !== 9'b110010000) begin
            failures++; $display("FAIL ret_lu got %b want 110010000", ctl);
        end
        advance(1, 1, 1, 0);
        idle();
        bus.M_icode = RET;
        #1;
        checks++;
        if (ctl !== 9'b101000000) begin
            failures++; $display("FAIL ret_m got %b want 101000000", ctl);
        end
        advance(1, 1, 1, 0);
        idle();
    endtask

    task automatic test_mispredict();
        bus.E_icode = JXX; bus.e_Cnd = 1'b0;
        #1;
        checks++;
        if (ctl !== 9'b001010000) begin
            failures++; $display("FAIL mispredict got %b want 001010000", ctl);
        end
        advance(1, 0, 1, 0);
        bus.e_Cnd = 1'b1;
        #1;
        checks++;
        if (ctl !== 9'b000000000) begin
            failures++; $display("FAIL jxx_taken got %b want 000000000", ctl);
        end
        advance(1, 0, 0, 0);
        idle();
        checks++;
        if ({bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt} !== {e_cyc[31:0], e_stall[31:0], e_bub[31:0]}) begin
            failures++;
            $display("FAIL mispredict_cnt got %0d %0d %0d want %0d %0d %0d", bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, e_cyc, e_stall, e_bub);
        end
    endtask

    task automatic test_retire();
        bus.W_icode = OPQ;
        advance(1, 0, 0, 1);
        bus.W_icode = HALT;
        advance(1, 0, 0, 0);
        bus.W_icode = CALL;
        advance(1, 0, 0, 1);
        idle();
        checks++;
        if (bus.retire_cnt !== e_ret[31:0]) begin
            failures++; $display("FAIL retire_cnt got %0d want %0d", bus.retire_cnt, e_ret);
        end
    endtask

    task automatic test_exception();
        bus.E_icode = OPQ;
        #1;
        checks++;
        if (ctl !== 9'b000000001) begin
            failures++; $display("FAIL opq_setcc got %b want 000000001", ctl);
        end
        advance(1, 0, 0, 0);
        bus.m_stat = ADR;
        #1;
        checks++;
        if (ctl !== 9'b000000100) begin
            failures++; $display("FAIL m_exc got %b want 000000100", ctl);
        end
        advance(1, 0, 0, 0);
        bus.m_stat = AOK; bus.W_stat = ADR; bus.W_icode = OPQ;
        #1;
        checks++;
        if ({ctl, bus.fault} !== 10'b0000001100) begin
            failures++; $display("FAIL w_exc got %b fault %b want 000000110 fault 0", ctl, bus.fault);
        end
        advance(1, 0, 0, 0);
        idle();
        #1;
        checks++;
        if ({ctl, bus.fault} !== 10'b1100101101) begin
            failures++; $display("FAIL fault_ctl got %b fault %b want 110010110 fault 1", ctl, bus.fault);
        end
        advance(0, 0, 0, 0);
        bus.dbg_halt_req = 1'b1; bus.W_icode = OPQ;
        advance(0, 0, 0, 0);
        checks++;
        if ({bus.fault, bus.dbg_halted} !== 2'b10) begin
            failures++; $display("FAIL fault_sticky got fault %b halted %b want 1 0", bus.fault, bus.dbg_halted);
        end
        checks++;
        if ({bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt} !== {e_cyc[31:0], e_stall[31:0], e_bub[31:0], e_ret[31:0]}) begin
            failures++;
            $display("FAIL fault_cnt got %0d %0d %0d %0d want %0d %0d %0d %0d", bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt, e_cyc, e_stall, e_bub, e_ret);
        end
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        e_cyc = 0; e_stall = 0; e_bub = 0; e_ret = 0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.fault, bus.cyc_cnt, bus.retire_cnt} !== 65'd0) begin
            failures++; $display("FAIL fault_reset got fault %b cyc %0d ret %0d want 0 0 0", bus.fault, bus.cyc_cnt, bus.retire_cnt);
        end
        advance(1, 0, 0, 0);
    endtask

    task automatic test_debug();
        bus.dbg_step = 1'b1;
        advance(1, 0, 0, 0);
        bus.dbg_step = 1'b0;
        checks++;
        if (bus.dbg_halted !== 1'b0) begin
            failures++; $display("FAIL step_in_run got halted %b want 0", bus.dbg_halted);
        end
        bus.dbg_halt_req = 1'b1;
        #1;
        checks++;
        if ({ctl, bus.dbg_halted} !== 10'b0000000000) begin
            failures++; $display("FAIL halt_sample got %b halted %b want 000000000 0", ctl, bus.dbg_halted);
        end
        advance(1, 0, 0, 0);
        bus.E_icode = JXX; bus.e_Cnd = 1'b0;
        #1;
        checks++;
        if ({ctl, bus.dbg_halted} !== 10'b1101010101) begin
            failures++; $display("FAIL halted_ctl got %b halted %b want 110101010 1", ctl, bus.dbg_halted);
        end
        advance(0, 0, 0, 0);
        advance(0, 0, 0, 0);
        checks++;
        if (bus.cyc_cnt !== e_cyc[31:0]) begin
            failures++; $display("FAIL halted_cyc got %0d want %0d", bus.cyc_cnt, e_cyc);
        end
        bus.dbg_step = 1'b1;
        advance(0, 0, 0, 0);
        bus.dbg_step = 1'b0;
        #1;
        checks++;
        if ({ctl, bus.dbg_halted} !== 10'b0010100000) begin
            failures++; $display("FAIL step_ctl got %b halted %b want 001010000 0", ctl, bus.dbg_halted);
        end
        advance(1, 0, 1, 0);
        checks++;
        if ({bus.dbg_halted, bus.cyc_cnt, bus.bubble_cnt} !== {1'b1, e_cyc[31:0], e_bub[31:0]}) begin
            failures++; $display("FAIL step_done got halted %b cyc %0d bub %0d want 1 %0d %0d", bus.dbg_halted, bus.cyc_cnt, bus.bubble_cnt, e_cyc, e_bub);
        end
        bus.dbg_halt_req = 1'b0;
        advance(0, 0, 0, 0);
        idle();
        #1;
        checks++;
        if ({ctl, bus.dbg_halted} !== 10'b0000000000) begin
            failures++; $display("FAIL resume got %b halted %b want 000000000 0", ctl, bus.dbg_halted);
        end
        advance(1, 0, 0, 0);
        checks++;
        if (bus.cyc_cnt !== e_cyc[31:0]) begin
            failures++; $display("FAIL resume_cyc got %0d want %0d", bus.cyc_cnt, e_cyc);
        end
    endtask

    task automatic test_reset_mid_step();
        bus.dbg_halt_req = 1'b1;
        advance(1, 0, 0, 0);
        bus.dbg_step = 1'b1;
        advance(0, 0, 0, 0);
        bus.dbg_step = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        e_cyc = 0; e_stall = 0; e_bub = 0; e_ret = 0;
        rst_n = 1'b1;
        bus.dbg_halt_req = 1'b0;
        #1;
        checks++;
        if ({bus.dbg_halted, bus.fault, bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt} !== 130'd0) begin
            failures++;
            $display("FAIL reset_step got halted %b fault %b cnt %0d %0d %0d %0d want 0 0 0 0 0 0", bus.dbg_halted, bus.fault, bus.cyc_cnt, bus.stall_cnt, bus.bubble_cnt, bus.retire_cnt);
        end
        advance(1, 0, 0, 0);
        checks++;
        if ({bus.dbg_halted, bus.cyc_cnt} !== {1'b0, e_cyc[31:0]}) begin
            failures++; $display("FAIL after_reset got halted %b cyc %0d want 0 %0d", bus.dbg_halted, bus.cyc_cnt, e_cyc);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        e_cyc = 0; e_stall = 0; e_bub = 0; e_ret = 0;
        test_reset();
        test_load_use();
        test_ret();
        test_mispredict();
        test_retire();
        test_exception();
        test_debug();
        test_reset_mid_step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_sched.md
Name: pipe_ctrl_sched

Overview:
- Central pipeline control unit for the 5-stage Y86-64 pipeline.
- Each cycle it generates the stall/bubble controls for the F, D, E, M and W pipeline registers, including the W register's W_stall, plus set_cc.
- Adds a registered run/debug/fault state machine (freeze, single-step, sticky fault) and performance counters.
- Sits beside the stage registers. Consumes decode/execute/memory/writeback status and drives every register's control pins.

Parameters:
- CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- D_icode  in  4  icode held in the D register.
- d_srcA  in  4  decode source A (RNONE=4'hF).
- d_srcB  in  4  decode source B.
- E_icode  in  4  icode held in the E register.
- E_dstM  in  4  E register dstM.
- e_Cnd  in  1  execute-stage branch condition.
- M_icode  in  4  icode held in the M register.
- m_stat  in  2  memory-stage status.
- W_icode  in  4  icode held in the W register.
- W_stat  in  2  W register status.
- dbg_halt_req  in  1  level: request pipeline freeze.
- dbg_step  in  1  one-cycle pulse: advance one cycle while frozen.
- F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall  out  1 each  register controls.
- set_cc  out  1  condition-code write enable.
- dbg_halted  out  1  high in DBG_HALT.
- fault  out  1  high in FAULT.
- cyc_cnt, stall_cnt, bubble_cnt, retire_cnt  out  CNT_W each  performance counters.

Behaviour:
- Encodings: stat AOK=0, HLT=1, ADR=2, INS=3. icode HALT=0, NOP=1 … JXX=7, CALL=8, RET=9, POPQ=B, MRMOVQ=5, OPQ=6.
- Hazard terms, all combinational:
  - lu = (E_icode in {MRMOVQ, POPQ}) && E_dstM != RNONE && (E_dstM == d_srcA || E_dstM == d_srcB).
  - rt = RET in {D_icode, E_icode, M_icode}.
  - mp = E_icode == JXX && !e_Cnd.
  - exc = m_stat != AOK || W_stat != AOK.
- Normal control (RUN, STEP):
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exc.
  - W_stall = W_stat != AOK.
  - set_cc = E_icode == OPQ && !exc.
  - E_stall = M_stall = 0.
  - A stall and a bubble are never both asserted on one register; stall wins.
- Frozen control (DBG_HALT): all *_stall = 1, all bubbles = 0, set_cc = 0.
- FAULT control: W_stall = 1, M_bubble = 1, set_cc = 0, F_stall = 1, D_stall = 1, E_bubble = 1. Everything else is 0.
- State register: RUN, DBG_HALT, STEP, FAULT. Reset state is RUN.
- Transitions, evaluated at the rising edge in priority order:
  1. Any state with W_stat != AOK goes to FAULT. FAULT is sticky until rst_n.
  2. RUN with dbg_halt_req goes to DBG_HALT.
  3. DBG_HALT with dbg_step goes to STEP.
  4. DBG_HALT with !dbg_halt_req goes to RUN.
  5. STEP lasts exactly one cycle, then goes to DBG_HALT if dbg_halt_req is high, else RUN.
- dbg_step outside DBG_HALT is ignored.
- Entry into DBG_HALT takes effect the cycle after dbg_halt_req is sampled. Control outputs in that sampling cycle are still normal.
- Counters: synchronous, with wrap-around.
  - cyc_cnt increments in RUN and STEP.
  - stall_cnt increments when F_stall in RUN/STEP.
  - bubble_cnt increments when (D_bubble | E_bubble) in RUN/STEP.
  - retire_cnt increments when W_stat == AOK && W_icode != NOP && W_icode != HALT in RUN/STEP.
  - All counters hold in DBG_HALT and FAULT.
- Reset, while rst_n is low at the edge, from any state:
  - state = RUN, all counters = 0.
  - dbg_halted = 0, fault = 0.
  - Combinational controls follow their inputs in RUN mode.

Decomposition:
- Shared package y86_pkg holds:
  - stat constants (AOK, HLT, ADR, INS),
  - icode constants (HALT…POPQ),
  - RNONE,
  - the ctrl_state enum (RUN, DBG_HALT, STEP, FAULT).
- One natural sub-module: hazard_detect. It is purely combinational and computes lu, rt, mp, exc. The top module holds the FSM, output muxing and counters.

Test Plan:
- Load/use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, stall_cnt +1.
- Ret in flight: D_icode=RET, no lu -> F_stall=1, D_bubble=1. Same with E_icode=MRMOVQ, E_dstM=2, d_srcB=2 -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=JXX, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0, bubble_cnt +1.
- Exception: m_stat=ADR, E_icode=OPQ -> M_bubble=1, set_cc=0. Next W_stat=ADR -> fault=1 next cycle, W_stall=1, and fault stays set after W_stat returns to AOK until rst_n=0.
- Debug: dbg_halt_req=1 for 1 cycle, then dbg_halted=1 with all stalls =1 and cyc_cnt frozen. dbg_step pulse -> exactly one cycle of normal controls and cyc_cnt +1, then back to halted. Dropping dbg_halt_req -> RUN.
- Reset mid-STEP: rst_n=0 while in STEP -> state RUN, all counters 0, dbg_halted=0 on the next edge.
